// File: rtl/nibble_serial_subtractor_16bit.sv
// -----------------------------------------------------------------------------
// nibble_serial_subtractor_16bit
//
// Digit-serial subtractor: diff = a - b (mod 2^WIDTH), DIGIT bits per clock,
// least-significant digit first. A registered borrow links one digit step to
// the next, so a single DIGIT-wide subtract stage is reused NDIG times.
//
// Flow: IDLE accepts operands -> BUSY runs NDIG digit steps -> DONE presents
// the result until the consumer takes it -> IDLE.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_valid   in   operands a/b valid
//   in_ready   out  block can accept operands (IDLE only)
//   a          in   minuend   [WIDTH-1:0]
//   b          in   subtrahend [WIDTH-1:0]
//   out_valid  out  result valid (DONE only)
//   out_ready  in   consumer accepts result
//   diff       out  a - b modulo 2^WIDTH [WIDTH-1:0]
//   bout       out  final borrow, 1 iff a < b (unsigned)
//   ovf        out  signed overflow of the two's-complement subtraction
// -----------------------------------------------------------------------------
module nibble_serial_subtractor_16bit #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_bout;
    logic               r_ovf;

    logic [DIGIT-1:0]   w_a_dig;
    logic [DIGIT-1:0]   w_b_dig;
    logic [DIGIT:0]     w_sub;

    // Digit currently being processed.
    assign w_a_dig = r_a[r_cnt*DIGIT +: DIGIT];
    assign w_b_dig = r_b[r_cnt*DIGIT +: DIGIT];

    // One extra bit on the left: the subtraction goes negative exactly when
    // a_dig < b_dig + borrow_in, and that shows up as a 1 in bit DIGIT.
    assign w_sub = {1'b0, w_a_dig} - {1'b0, w_b_dig} - {{DIGIT{1'b0}}, r_borrow};

    assign w_last = (r_cnt == CNT_W'(NDIG - 1));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples values from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and handshake outputs
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before the case statement;
    // a path that left one unassigned would infer a latch.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;

        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    // diff/bout/ovf are only written in BUSY, so they hold through DONE and
    // keep their last values after the output handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (r_state == BUSY) begin
            r_diff[r_cnt*DIGIT +: DIGIT] <= w_sub[DIGIT-1:0];
            r_borrow                     <= w_sub[DIGIT];
            r_cnt                        <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_bout <= w_sub[DIGIT];
                // Overflow only possible when operand signs differ; it happened
                // if the result sign disagrees with the minuend sign.
                r_ovf  <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                          (w_sub[DIGIT-1] != r_a[WIDTH-1]);
            end
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_subtractor_16bit.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_subtractor_16bit
//
// Directed bench for the digit-serial subtractor. Inputs change 1 ns after a
// rising edge and outputs are sampled at that same point, well away from the
// next active edge.
// -----------------------------------------------------------------------------
module tb_nibble_serial_subtractor_16bit;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             bo;
        logic             ov;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    nibble_serial_subtractor_16bit #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for out_valid; returns the number of edges waited.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 32) begin
            tick();
            lat++;
        end
    endtask

    // Full operation with out_ready held high: accept, latency, result, handshake.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic [WIDTH-1:0] ed, input logic eb, input logic eo);
        int lat;
        a         = ta;
        b         = tb_v;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check({tag, "_ready_idle"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check({tag, "_ready_busy"}, 32'(in_ready), 32'd0);
        wait_valid(lat);
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_bout"}, 32'(bout), 32'(eb));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
        check({tag, "_ready_done"}, 32'(in_ready), 32'd0);
        tick();
        check({tag, "_valid_after_hs"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_after_hs"}, 32'(in_ready), 32'd1);
        check({tag, "_diff_held"}, 32'(diff), 32'(ed));
    endtask

    initial begin
        int   lat;
        int   n_sent;
        int   n_recv;
        int   last_acc;
        bit   acc_now;
        exp_t q[$];
        exp_t e;
        logic [WIDTH-1:0] bb_a [3];
        logic [WIDTH-1:0] bb_b [3];

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff",      32'(diff),      32'd0);
        check("rst_bout",      32'(bout),      32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);

        // Basic, borrow chain, signed overflow
        run_op("basic",    16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0);
        run_op("chain",    16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0);
        run_op("wrap",     16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
        run_op("ovf_neg",  16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
        run_op("ovf_pos",  16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1);
        run_op("equal",    16'h4C4C, 16'h4C4C, 16'h0000, 1'b0, 1'b0);

        // Back-pressure: result must hold, new operands must be ignored
        out_ready = 1'b0;
        a         = 16'hABCD;
        b         = 16'h1111;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a        = 16'($urandom);
            b        = 16'($urandom);
            tick();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_diff",  32'(diff),      32'h9ABC);
            check("bp_ready", 32'(in_ready),  32'd0);
        end
        check("bp_bout", 32'(bout), 32'd0);
        check("bp_ovf",  32'(ovf),  32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_hs_valid", 32'(out_valid), 32'd0);
        check("bp_hs_ready", 32'(in_ready),  32'd1);
        check("bp_hs_diff",  32'(diff),      32'h9ABC);
        tick();
        check("bp_idle_ready", 32'(in_ready),  32'd1);
        check("bp_idle_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of BUSY aborts the operation
        out_ready = 1'b0;
        a         = 16'h5555;
        b         = 16'h2222;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready", 32'(in_ready),  32'd1);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_diff",  32'(diff),      32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("abort_no_valid", 32'(out_valid), 32'd0);
        end
        run_op("after_abort", 16'h5555, 16'h2222, 16'h3333, 1'b0, 1'b0);

        // Back-to-back with in_valid and out_ready held high, scoreboarded
        bb_a[0] = 16'hFFFF; bb_b[0] = 16'hFFFF;
        bb_a[1] = 16'h0001; bb_b[1] = 16'h0002;
        bb_a[2] = 16'h8000; bb_b[2] = 16'h8000;
        n_sent    = 0;
        n_recv    = 0;
        last_acc  = 0;
        a         = bb_a[0];
        b         = bb_b[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 80 && n_recv < 3; i++) begin
            acc_now = (in_valid === 1'b1) && (in_ready === 1'b1);
            tick();
            if (acc_now) begin
                if (n_sent > 0) check("b2b_spacing", 32'(cyc - last_acc), 32'd6);
                last_acc = cyc;
                e.d  = a - b;
                e.bo = (a < b);
                e.ov = (a[WIDTH-1] != b[WIDTH-1]) && (e.d[WIDTH-1] != a[WIDTH-1]);
                q.push_back(e);
                n_sent++;
                if (n_sent < 3) begin
                    a = bb_a[n_sent];
                    b = bb_b[n_sent];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid === 1'b1) begin
                check("b2b_queue_nonempty", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("b2b_diff", 32'(diff), 32'(e.d));
                    check("b2b_bout", 32'(bout), 32'(e.bo));
                    check("b2b_ovf",  32'(ovf),  32'(e.ov));
                end
                n_recv++;
            end
        end
        check("b2b_count", 32'(n_recv), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
